// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline register bank:
// the stage control bundle, forward-select encodings and the bubble value.
package pipe_pkg;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic [2:0] alucontrol;
        logic       alusrc;
    } ctrl_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_flop.sv
// Generic stage register: async active-low reset to RST_VAL, enable, and a
// synchronous clear that only takes effect when the register is enabled.
module pipe_flop #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // A stalled stage keeps its contents even if a clear arrives that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_clr ? '0 : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipeline_regs.sv
// Pipeline-register bank of the five-stage MIPS core: PC, IF/ID, ID/EX, EX/MEM,
// MEM/WB, plus execute-stage forwarding muxes and the writeback result mux.
module pipeline_regs
    import pipe_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pcnextF,
    input  logic [W-1:0] instrF,
    input  logic [W-1:0] pcplus4F,
    output logic [W-1:0] pcF,
    output logic [W-1:0] instrD,
    output logic [W-1:0] pcplus4D,
    input  logic         stallF,
    input  logic         stallD,
    input  logic         flushE,
    input  logic         pcsrcD,
    input  logic [6:0]   ctrlD,
    input  logic         regdstD,
    input  logic [W-1:0] rd1D,
    input  logic [W-1:0] rd2D,
    input  logic [W-1:0] signimmD,
    input  logic [4:0]   rsD,
    input  logic [4:0]   rtD,
    input  logic [4:0]   rdD,
    output logic [4:0]   rsE,
    output logic [4:0]   rtE,
    output logic [4:0]   writeregE,
    output logic         regwriteE,
    output logic         memtoregE,
    output logic [2:0]   alucontrolE,
    output logic         alusrcE,
    output logic [W-1:0] signimmE,
    input  logic [1:0]   forwardaE,
    input  logic [1:0]   forwardbE,
    output logic [W-1:0] srcaE,
    output logic [W-1:0] writedataE,
    input  logic [W-1:0] aluoutE,
    output logic [W-1:0] aluoutM,
    output logic [W-1:0] writedataM,
    output logic [4:0]   writeregM,
    output logic         regwriteM,
    output logic         memtoregM,
    output logic         memwriteM,
    input  logic [W-1:0] readdataM,
    output logic [W-1:0] resultW,
    output logic [4:0]   writeregW,
    output logic         regwriteW
);

    localparam int FD_W = 2 * W;
    localparam int DE_W = $bits(ctrl_t) + 1 + 3 * W + 15;
    localparam int EM_W = 3 + 2 * W + 5;
    localparam int MW_W = 2 + 2 * W + 5;

    logic [FD_W-1:0] w_fd_q;
    logic [DE_W-1:0] w_de_d, w_de_q;
    logic [EM_W-1:0] w_em_q;
    logic [MW_W-1:0] w_mw_q;
    ctrl_t           w_ctrl_in, w_ctrlE;
    logic            w_regdstE, w_memtoregW;
    logic [4:0]      w_rdE;
    logic [W-1:0]    w_rd1E, w_rd2E, w_aluoutW, w_readdataW;

    pipe_flop #(.WIDTH(W), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst_n(rst_n), .i_en(~stallF), .i_clr(1'b0),
        .i_d(pcnextF), .o_q(pcF)
    );

    pipe_flop #(.WIDTH(FD_W)) u_ifid (
        .clk(clk), .rst_n(rst_n), .i_en(~stallD), .i_clr(pcsrcD),
        .i_d({instrF, pcplus4F}), .o_q(w_fd_q)
    );
    assign {instrD, pcplus4D} = w_fd_q;

    // ID/EX is never stalled; a load-use hazard holds F/D while E takes the bubble.
    assign w_ctrl_in = flushE ? BUBBLE : ctrl_t'(ctrlD);
    assign w_de_d    = {w_ctrl_in, regdstD, rd1D, rd2D, signimmD, rsD, rtD, rdD};

    pipe_flop #(.WIDTH(DE_W)) u_idex (
        .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(flushE),
        .i_d(w_de_d), .o_q(w_de_q)
    );
    assign {w_ctrlE, w_regdstE, w_rd1E, w_rd2E, signimmE, rsE, rtE, w_rdE} = w_de_q;

    assign regwriteE   = w_ctrlE.regwrite;
    assign memtoregE   = w_ctrlE.memtoreg;
    assign alucontrolE = w_ctrlE.alucontrol;
    assign alusrcE     = w_ctrlE.alusrc;
    assign writeregE   = w_regdstE ? w_rdE : rtE;

    // FWD_RF and the reserved 2'b11 both pass the register-file operand.
    always_comb begin
        srcaE = w_rd1E;
        case (forwardaE)
            FWD_WB:  srcaE = resultW;
            FWD_MEM: srcaE = aluoutM;
            default: srcaE = w_rd1E;
        endcase
    end

    always_comb begin
        writedataE = w_rd2E;
        case (forwardbE)
            FWD_WB:  writedataE = resultW;
            FWD_MEM: writedataE = aluoutM;
            default: writedataE = w_rd2E;
        endcase
    end

    pipe_flop #(.WIDTH(EM_W)) u_exmem (
        .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(1'b0),
        .i_d({regwriteE, memtoregE, w_ctrlE.memwrite, aluoutE, writedataE, writeregE}),
        .o_q(w_em_q)
    );
    assign {regwriteM, memtoregM, memwriteM, aluoutM, writedataM, writeregM} = w_em_q;

    pipe_flop #(.WIDTH(MW_W)) u_memwb (
        .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(1'b0),
        .i_d({regwriteM, memtoregM, aluoutM, readdataM, writeregM}),
        .o_q(w_mw_q)
    );
    assign {regwriteW, w_memtoregW, w_aluoutW, w_readdataW, writeregW} = w_mw_q;

    assign resultW = w_memtoregW ? w_readdataW : w_aluoutW;

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed bench for pipeline_regs: reset, latency, stalls, flush, branch clear,
// forwarding table and asynchronous reset during a flush.
module tb_pipeline_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pcnextF, instrF, pcplus4F, pcF, instrD, pcplus4D;
    logic        stallF, stallD, flushE, pcsrcD;
    logic [6:0]  ctrlD;
    logic        regdstD;
    logic [31:0] rd1D, rd2D, signimmD;
    logic [4:0]  rsD, rtD, rdD, rsE, rtE, writeregE;
    logic        regwriteE, memtoregE, alusrcE;
    logic [2:0]  alucontrolE;
    logic [31:0] signimmE;
    logic [1:0]  forwardaE, forwardbE;
    logic [31:0] srcaE, writedataE, aluoutE, aluoutM, writedataM;
    logic [4:0]  writeregM, writeregW;
    logic        regwriteM, memtoregM, memwriteM, regwriteW;
    logic [31:0] readdataM, resultW;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [1:0]  fwd;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } fwd_vec_t;

    fwd_vec_t vecs[4];

    pipeline_regs #(.W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .pcnextF(pcnextF), .instrF(instrF), .pcplus4F(pcplus4F),
        .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D),
        .stallF(stallF), .stallD(stallD), .flushE(flushE), .pcsrcD(pcsrcD),
        .ctrlD(ctrlD), .regdstD(regdstD),
        .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD),
        .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE),
        .alucontrolE(alucontrolE), .alusrcE(alusrcE), .signimmE(signimmE),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .srcaE(srcaE), .writedataE(writedataE),
        .aluoutE(aluoutE),
        .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
        .readdataM(readdataM),
        .resultW(resultW), .writeregW(writeregW), .regwriteW(regwriteW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pcnextF = '0; instrF = '0; pcplus4F = '0;
        stallF = 1'b0; stallD = 1'b0; flushE = 1'b0; pcsrcD = 1'b0;
        ctrlD = '0; regdstD = 1'b0;
        rd1D = '0; rd2D = '0; signimmD = '0;
        rsD = '0; rtD = '0; rdD = '0;
        forwardaE = 2'b00; forwardbE = 2'b00;
        aluoutE = '0; readdataM = '0;
    endtask

    initial begin
        vecs[0] = '{fwd: 2'b00, exp_a: 32'h11, exp_b: 32'h55};
        vecs[1] = '{fwd: 2'b01, exp_a: 32'h33, exp_b: 32'h33};
        vecs[2] = '{fwd: 2'b10, exp_a: 32'h22, exp_b: 32'h22};
        vecs[3] = '{fwd: 2'b11, exp_a: 32'h11, exp_b: 32'h55};

        // Reset with garbage on every input
        pcnextF = $urandom; instrF = $urandom; pcplus4F = $urandom;
        stallF = 1'($urandom); stallD = 1'($urandom); flushE = 1'($urandom);
        pcsrcD = 1'($urandom); ctrlD = 7'($urandom); regdstD = 1'($urandom);
        rd1D = $urandom; rd2D = $urandom; signimmD = $urandom;
        rsD = 5'($urandom); rtD = 5'($urandom); rdD = 5'($urandom);
        forwardaE = 2'($urandom_range(0, 3)); forwardbE = 2'($urandom_range(0, 3));
        aluoutE = $urandom; readdataM = $urandom;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pcF", pcF, 32'h0);
        chk("rst_instrD", instrD, 32'h0);
        chk("rst_regwriteE", 32'(regwriteE), 32'h0);
        chk("rst_writeregE", 32'(writeregE), 32'h0);
        chk("rst_srcaE", srcaE, 32'h0);
        chk("rst_writedataE", writedataE, 32'h0);
        step();
        chk("rst_hold_regwriteM", 32'(regwriteM), 32'h0);
        chk("rst_hold_regwriteW", 32'(regwriteW), 32'h0);
        chk("rst_hold_resultW", resultW, 32'h0);

        clear_inputs();
        pcnextF = 32'h4;
        rst_n = 1'b1;
        chk("release_pcF_sync", pcF, 32'h0);
        step();
        chk("release_pcF", pcF, 32'h4);
        chk("release_instrD", instrD, 32'h0);

        // Straight-line: addi $t0,$0,5 through D, E, M, W
        instrF = 32'h2008_0005; pcplus4F = 32'h8; pcnextF = 32'h8;
        step();
        chk("sl_instrD", instrD, 32'h2008_0005);
        chk("sl_pcplus4D", pcplus4D, 32'h8);
        chk("sl_regwriteE_early", 32'(regwriteE), 32'h0);
        instrF = '0; pcnextF = 32'hC;
        ctrlD = 7'b100_010_1; rtD = 5'd8; rdD = 5'd3; regdstD = 1'b0; signimmD = 32'h5;
        step();
        chk("sl_regwriteE", 32'(regwriteE), 32'h1);
        chk("sl_alucontrolE", 32'(alucontrolE), 32'h2);
        chk("sl_alusrcE", 32'(alusrcE), 32'h1);
        chk("sl_writeregE", 32'(writeregE), 32'd8);
        chk("sl_signimmE", signimmE, 32'h5);
        ctrlD = '0; rtD = '0; rdD = '0; signimmD = '0; aluoutE = 32'h5;
        step();
        chk("sl_regwriteM", 32'(regwriteM), 32'h1);
        chk("sl_aluoutM", aluoutM, 32'h5);
        chk("sl_writeregM", 32'(writeregM), 32'd8);
        chk("sl_regwriteE_next", 32'(regwriteE), 32'h0);
        aluoutE = '0;
        step();
        chk("sl_regwriteW", 32'(regwriteW), 32'h1);
        chk("sl_resultW", resultW, 32'h5);
        chk("sl_writeregW", 32'(writeregW), 32'd8);

        // Load-use: lw in D, then stall F/D with a bubble into E
        instrF = 32'h8c09_0000; pcnextF = 32'h10;
        ctrlD = 7'b110_010_1; rsD = 5'd1; rtD = 5'd9;
        step();
        chk("lu_setup_instrD", instrD, 32'h8c09_0000);
        chk("lu_setup_memtoregE", 32'(memtoregE), 32'h1);
        stallF = 1'b1; stallD = 1'b1; flushE = 1'b1;
        instrF = 32'h0109_5020; pcnextF = 32'h14;
        ctrlD = 7'b100_010_0; rsD = 5'd8; rtD = 5'd9; rdD = 5'd10; regdstD = 1'b1;
        step();
        chk("lu_pcF_hold", pcF, 32'h10);
        chk("lu_instrD_hold", instrD, 32'h8c09_0000);
        chk("lu_regwriteE", 32'(regwriteE), 32'h0);
        chk("lu_memtoregE", 32'(memtoregE), 32'h0);
        chk("lu_rsE", 32'(rsE), 32'h0);
        chk("lu_rtE", 32'(rtE), 32'h0);
        chk("lu_writeregE", 32'(writeregE), 32'h0);
        chk("lu_regwriteM_adv", 32'(regwriteM), 32'h1);
        chk("lu_memtoregM_adv", 32'(memtoregM), 32'h1);
        stallF = 1'b0; stallD = 1'b0; flushE = 1'b0;
        step();
        chk("lu_resume_pcF", pcF, 32'h14);
        chk("lu_resume_instrD", instrD, 32'h0109_5020);
        chk("lu_resume_regwriteE", 32'(regwriteE), 32'h1);
        chk("lu_resume_rsE", 32'(rsE), 32'd8);
        chk("lu_resume_writeregE", 32'(writeregE), 32'd10);
        chk("lu_bubble_regwriteM", 32'(regwriteM), 32'h0);

        // Branch clear, then clear suppressed by stall, then stallF alone
        ctrlD = '0; rsD = '0; rtD = '0; rdD = '0; regdstD = 1'b0;
        instrF = 32'h0000_ABCD; pcplus4F = 32'h100; pcnextF = 32'h18;
        pcsrcD = 1'b1;
        step();
        chk("br_instrD_clr", instrD, 32'h0);
        chk("br_pcplus4D_clr", pcplus4D, 32'h0);
        pcsrcD = 1'b0;
        step();
        chk("br_instrD_load", instrD, 32'h0000_ABCD);
        pcsrcD = 1'b1; stallD = 1'b1; instrF = 32'h0000_1234; pcnextF = 32'h1C;
        step();
        chk("br_stall_instrD", instrD, 32'h0000_ABCD);
        chk("br_stall_pcplus4D", pcplus4D, 32'h100);
        chk("br_stallD_only_pcF", pcF, 32'h1C);
        pcsrcD = 1'b0; stallD = 1'b0; stallF = 1'b1; pcnextF = 32'h20;
        step();
        chk("stallF_only_pcF", pcF, 32'h1C);
        chk("stallF_only_instrD", instrD, 32'h0000_1234);
        stallF = 1'b0;

        // Forwarding: rd1E=11, rd2E=55, aluoutM=22, resultW=33
        instrF = '0; ctrlD = '0; rd1D = 32'h11; rd2D = 32'h55;
        step();
        aluoutE = 32'h33;
        step();
        aluoutE = 32'h22;
        step();
        for (int i = 0; i < 4; i++) begin
            forwardaE = vecs[i].fwd;
            forwardbE = vecs[i].fwd;
            #1;
            chk($sformatf("fwd_a_%0d", i), srcaE, vecs[i].exp_a);
            chk($sformatf("fwd_b_%0d", i), writedataE, vecs[i].exp_b);
        end
        forwardaE = FWD_MEM_TB(); forwardbE = 2'b01;
        #1;
        chk("fwd_mixed_a", srcaE, 32'h22);
        chk("fwd_mixed_b", writedataE, 32'h33);
        forwardaE = 2'b00; forwardbE = 2'b00;

        // Writeback selects readdata when memtoreg is set
        ctrlD = 7'b010_000_0;
        step();
        ctrlD = '0;
        step();
        aluoutE = 32'h77; readdataM = 32'hDEAD_BEEF;
        step();
        chk("wb_memtoreg_result", resultW, 32'hDEAD_BEEF);
        readdataM = '0;
        step();
        chk("wb_alu_result", resultW, 32'h77);

        // Asynchronous reset during flush + stall
        ctrlD = 7'b111_111_1; rsD = 5'd4; rtD = 5'd5; rd1D = 32'hAA; pcnextF = 32'h40;
        step();
        step();
        flushE = 1'b1; stallD = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pcF", pcF, 32'h0);
        chk("arst_instrD", instrD, 32'h0);
        chk("arst_regwriteM", 32'(regwriteM), 32'h0);
        chk("arst_regwriteW", 32'(regwriteW), 32'h0);
        chk("arst_aluoutM", aluoutM, 32'h0);
        chk("arst_resultW", resultW, 32'h0);
        chk("arst_srcaE", srcaE, 32'h0);
        chk("arst_rsE", 32'(rsE), 32'h0);
        clear_inputs();
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    function automatic logic [1:0] FWD_MEM_TB();
        return 2'b10;
    endfunction

endmodule
